lfsr_32bits_checker: RTL and testbench
======================================

// Module: lfsr_32bits_checker
// PURPOSE
//   Receive-side checker for the 32-bit PRBS stream (x^32+x^30+x^11+x^5+1) emitted one bit per
//   update by the 32-bit LFSR generator (stream bit = generator val[0] before each shift).
//   Self-seeds from the first 32 received bits, then predicts every following bit, flags mismatches,
//   keeps a saturating error count and drops back to re-seeding on sustained loss of lock.
//   Sits at the far end of BIST/link-test paths and in self-test benches fed by the generator.
// PARAMETERS
//   CNT_W        16   width of err_count (and bit_count when enabled)
//   WIN_LEN      256  checked bits per loss-of-lock window (>=2)
//   LOSS_THRESH  8    mismatches within one window that force re-seed (1..WIN_LEN)
// PORTS
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      in_bit is valid this cycle
//   in_bit     in   1      received stream bit
//   clear      in   1      zero err_count (and bit_count)
//   locked     out  1      1 while in CHECK state
//   err_pulse  out  1      one-cycle flag: the previous accepted bit mismatched
//   err_count  out  CNT_W  saturating mismatch total
//   bit_count  out  CNT_W  saturating checked-bit total (only with LFSR_CHK_BITCNT_EN)
// BEHAVIOUR
// - Reset: state=SEED, shift reg s=0, seed count=0, window counters=0; locked=0, err_pulse=0,
//   err_count=0, bit_count=0. All outputs registered.
// - Shift rule (both states): s <= {b, s[31:1]}; s[0] oldest. pred = s[0]^s[2]^s[21]^s[27].
// - SEED: each in_valid cycle shifts b=in_bit, seed count +1. On the 32nd bit: if resulting s==0
//   stay in SEED, seed count=0 (all-zero is not a legal state); else -> CHECK. locked rises the
//   cycle after the 32nd bit is accepted. No errors reported in SEED.
// - CHECK: each in_valid cycle compares in_bit vs pred; shifts b=pred (error does not propagate).
//   Mismatch: err_pulse=1 next cycle, err_count+1 saturating at all-ones, window error count +1.
//   Window bit count +1; when it reaches WIN_LEN both window counters reset to 0 (a mismatch on the
//   last bit of a window is evaluated against that window first).
//   Window error count reaching LOSS_THRESH -> SEED next cycle: locked=0, seed count=0, window
//   counters=0, s kept but fully overwritten by reseed; err_count retained.
// - in_valid=0: no state change; err_pulse=0.
// - clear: err_count (and bit_count) =0 next cycle, has priority over a same-cycle increment;
//   err_pulse, state and window counters unaffected.
// - rst mid-operation: returns to reset values next cycle regardless of other inputs.
// CONFIGURATION
//   LFSR_CHK_BITCNT_EN defined: bit_count increments (saturating) on every in_valid cycle in CHECK,
//   clear/rst zero it; gives BER = err_count/bit_count.
//   Not defined: bit_count port present, tied to 0; no counter logic.
// TESTING
// - Generator seeded 32'hdeadface, update every cycle, 1000 bits -> locked=1 after bit 32,
//   err_count=0, err_pulse never set.
// - Same, flip stream bit 100 -> exactly one err_pulse, err_count=1, locked stays 1.
// - LOSS_THRESH=8: flip 8 bits within one 256-bit window -> locked=0 next cycle, relocks 32 bits
//   later, err_count=8; 7 flips per window over 4 windows -> stays locked, err_count=28.
// - Feed 40 zero bits -> stays in SEED, locked=0, err_count=0.
// - CNT_W=4, continuous inverted stream after lock with LOSS_THRESH=WIN_LEN -> err_count saturates
//   at 15; assert clear with an error same cycle -> err_count=0.
// - Gapped in_valid (random 50%) plus rst asserted at bit 60 -> all outputs reset, relock correct.

Source files
------------

// File: rtl/lfsr_32bits_checker.sv
// Receive-side checker for the x^32+x^30+x^11+x^5+1 PRBS stream: self-seeds, predicts, counts errors.
// Define LFSR_CHK_BITCNT_EN to enable the saturating checked-bit counter on o_bit_count.
module lfsr_32bits_checker #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_LEN     = 256,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    input  logic             i_in_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_bit_count
);

    localparam int unsigned WB_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned WE_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic {ST_SEED, ST_CHECK} state_t;

    state_t           r_state;
    logic [31:0]      r_s;
    logic [4:0]       r_seed_cnt;
    logic [WB_W-1:0]  r_win_bits;
    logic [WE_W-1:0]  r_win_errs;
    logic             r_locked;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_count;

    logic             w_pred;
    logic             w_mis;
    logic             w_chk;
    logic [31:0]      w_seed_s;
    logic [WE_W-1:0]  w_win_errs_inc;

    assign w_pred         = r_s[0] ^ r_s[2] ^ r_s[21] ^ r_s[27];
    assign w_mis          = i_in_bit ^ w_pred;
    assign w_chk          = i_in_valid && (r_state == ST_CHECK);
    assign w_seed_s       = {i_in_bit, r_s[31:1]};
    assign w_win_errs_inc = r_win_errs + WE_W'(w_mis);

    assign o_locked    = r_locked;
    assign o_err_pulse = r_err_pulse;
    assign o_err_count = r_err_count;

    // Seed/check state machine, loss-of-lock window and error accounting
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_SEED;
            r_s         <= '0;
            r_seed_cnt  <= '0;
            r_win_bits  <= '0;
            r_win_errs  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_chk && w_mis;
            if (i_clear) begin
                r_err_count <= '0;
            end else if (w_chk && w_mis && !(&r_err_count)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end

            case (r_state)
                ST_SEED: begin
                    if (i_in_valid) begin
                        r_s <= w_seed_s;
                        if (r_seed_cnt == 5'd31) begin
                            r_seed_cnt <= '0;
                            // an all-zero register would lock up the predictor
                            if (w_seed_s != 32'd0) begin
                                r_state  <= ST_CHECK;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_seed_cnt <= r_seed_cnt + 5'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_in_valid) begin
                        r_s <= {w_pred, r_s[31:1]};
                        if (w_win_errs_inc == WE_W'(LOSS_THRESH)) begin
                            r_state    <= ST_SEED;
                            r_locked   <= 1'b0;
                            r_seed_cnt <= '0;
                            r_win_bits <= '0;
                            r_win_errs <= '0;
                        end else if (r_win_bits == WB_W'(WIN_LEN - 1)) begin
                            r_win_bits <= '0;
                            r_win_errs <= '0;
                        end else begin
                            r_win_bits <= r_win_bits + WB_W'(1);
                            r_win_errs <= w_win_errs_inc;
                        end
                    end
                end
                default: begin
                    r_state <= ST_SEED;
                end
            endcase
        end
    end

`ifdef LFSR_CHK_BITCNT_EN
    logic [CNT_W-1:0] r_bit_count;

    // Checked-bit total, the BER denominator
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_bit_count <= '0;
        end else if (w_chk && !(&r_bit_count)) begin
            r_bit_count <= r_bit_count + CNT_W'(1);
        end
    end

    assign o_bit_count = r_bit_count;
`else
    assign o_bit_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_32bits_checker.sv
// Directed bench for lfsr_32bits_checker: two instances (default, and CNT_W=4 narrow-window) share inputs.
module tb_lfsr_32bits_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_bit, clear;
    logic a_locked, a_pulse, b_locked, b_pulse;
    logic [15:0] a_err, a_bc;
    logic [3:0]  b_err, b_bc;

    lfsr_32bits_checker #(.CNT_W(16), .WIN_LEN(256), .LOSS_THRESH(8)) u_a (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_bit(in_bit), .i_clear(clear),
        .o_locked(a_locked), .o_err_pulse(a_pulse), .o_err_count(a_err), .o_bit_count(a_bc));

    lfsr_32bits_checker #(.CNT_W(4), .WIN_LEN(32), .LOSS_THRESH(32)) u_b (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_bit(in_bit), .i_clear(clear),
        .o_locked(b_locked), .o_err_pulse(b_pulse), .o_err_count(b_err), .o_bit_count(b_bc));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a 64-entry ring of the current epoch's stream, indexed by bit number
    int  m_n[2], m_we[2], m_wb[2], m_err[2], m_bc[2];
    bit  m_lock[2], m_pulse[2];
    bit  m_r[2][64];

    function automatic int win_of(input int k);  return (k == 0) ? 256 : 32;   endfunction
    function automatic int th_of(input int k);   return (k == 0) ? 8 : 32;     endfunction
    function automatic int max_of(input int k);  return (k == 0) ? 65535 : 15; endfunction

    task automatic model_step(input int k);
        bit inc, binc, pred, zero;
        inc = 0; binc = 0;
        if (rst) begin
            m_n[k] = 0; m_we[k] = 0; m_wb[k] = 0; m_err[k] = 0; m_bc[k] = 0;
            m_lock[k] = 0; m_pulse[k] = 0;
        end else begin
            m_pulse[k] = 0;
            if (in_valid) begin
                if (!m_lock[k]) begin
                    m_r[k][m_n[k] % 64] = in_bit;
                    m_n[k]++;
                    if (m_n[k] == 32) begin
                        zero = 1;
                        for (int j = 0; j < 32; j++) if (m_r[k][j]) zero = 0;
                        if (zero) m_n[k] = 0;
                        else      m_lock[k] = 1;
                    end
                end else begin
                    pred = m_r[k][(m_n[k]-32) % 64] ^ m_r[k][(m_n[k]-30) % 64]
                         ^ m_r[k][(m_n[k]-11) % 64] ^ m_r[k][(m_n[k]-5) % 64];
                    m_r[k][m_n[k] % 64] = pred;
                    m_n[k]++;
                    binc = 1;
                    if (pred != in_bit) begin
                        m_pulse[k] = 1; inc = 1; m_we[k]++;
                    end
                    m_wb[k]++;
                    if (m_we[k] >= th_of(k)) begin
                        m_lock[k] = 0; m_n[k] = 0; m_we[k] = 0; m_wb[k] = 0;
                    end else if (m_wb[k] == win_of(k)) begin
                        m_we[k] = 0; m_wb[k] = 0;
                    end
                end
            end
            if (clear) begin
                m_err[k] = 0; m_bc[k] = 0;
            end else begin
                if (inc && m_err[k] < max_of(k))  m_err[k]++;
                if (binc && m_bc[k] < max_of(k))  m_bc[k]++;
            end
        end
    endtask

    function automatic int exp_bc(input int k);
`ifdef LFSR_CHK_BITCNT_EN
        return m_bc[k];
`else
        return (k < 0) ? 1 : 0;
`endif
    endfunction

    int a_pulses = 0;
    int a_drops  = 0;
    bit a_prev_lock = 0;

    // Model advance and per-cycle compare of both instances
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        chk("A_locked", 32'(a_locked), 32'(m_lock[0]));
        chk("A_err_pulse", 32'(a_pulse), 32'(m_pulse[0]));
        chk("A_err_count", 32'(a_err), 32'(m_err[0]));
        chk("A_bit_count", 32'(a_bc), 32'(exp_bc(0)));
        chk("B_locked", 32'(b_locked), 32'(m_lock[1]));
        chk("B_err_pulse", 32'(b_pulse), 32'(m_pulse[1]));
        chk("B_err_count", 32'(b_err), 32'(m_err[1]));
        chk("B_bit_count", 32'(b_bc), 32'(exp_bc(1)));
        if (a_pulse === 1'b1) a_pulses++;
        if (a_prev_lock && a_locked === 1'b0) a_drops++;
        a_prev_lock = (a_locked === 1'b1);
    end

    logic [31:0] gen;
    bit gen_hist[0:39];

    task automatic gen_next(output bit b);
        b   = gen[0];
        gen = {gen[0] ^ gen[2] ^ gen[21] ^ gen[27], gen[31:1]};
    endtask

    task automatic apply(input bit v, input bit b, input bit c, input bit r);
        @(negedge clk);
        in_valid = v; in_bit = b; clear = c; rst = r;
        @(posedge clk);
        #2;
    endtask

    function automatic bit flip_at(input int mode, input int i);
        int o;
        case (mode)
            2: return i == 100;
            3: return i >= 100 && i <= 107;
            4: begin
                if (i < 32 || i >= 32 + 1024) return 0;
                o = (i - 32) % 256;
                return o >= 8 && o <= 68 && ((o - 8) % 10) == 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic run_stream(input int from, input int to, input int mode);
        bit g;
        for (int i = from; i < to; i++) begin
            gen_next(g);
            if (i < 40) gen_hist[i] = g;
            apply(1, g ^ flip_at(mode, i), 0, 0);
        end
    endtask

    task automatic start_test();
        apply(0, 0, 0, 1);
        apply(0, 0, 0, 0);
        gen = 32'hdeadface;
        a_pulses = 0;
        a_drops  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] first;
        bit g;
        int cnt;
        rst = 1; in_valid = 0; in_bit = 0; clear = 0;
        apply(0, 0, 0, 1);
        chk("reset_locked", 32'(a_locked), 0);
        chk("reset_err_count", 32'(a_err), 0);
        chk("reset_err_pulse", 32'(a_pulse), 0);

        // Clean stream: lock after exactly 32 bits, no errors
        start_test();
        run_stream(0, 31, 1);
        chk("t1_unlocked_bit31", 32'(a_locked), 0);
        run_stream(31, 32, 1);
        chk("t1_locked_bit32", 32'(a_locked), 1);
        run_stream(32, 1000, 1);
        for (int j = 0; j < 8; j++) first[j] = gen_hist[j];
        chk("gen_first_byte", 32'(first), 32'h0000_00ce);
        chk("gen_bit32", 32'(gen_hist[32]), 1);
        chk("t1_err_count", 32'(a_err), 0);
        chk("t1_pulses", 32'(a_pulses), 0);

        // Single flipped bit
        start_test();
        run_stream(0, 1000, 2);
        chk("t2_err_count", 32'(a_err), 1);
        chk("t2_pulses", 32'(a_pulses), 1);
        chk("t2_drops", 32'(a_drops), 0);
        chk("t2_locked", 32'(a_locked), 1);
        chk("t2_model_err", 32'(m_err[0]), 1);

        // Eight flips in one window: loss of lock, relock 32 bits later
        start_test();
        run_stream(0, 107, 3);
        chk("t3_locked_before_8th", 32'(a_locked), 1);
        run_stream(107, 108, 3);
        chk("t3_unlocked_after_8th", 32'(a_locked), 0);
        run_stream(108, 139, 3);
        chk("t3_reseeding", 32'(a_locked), 0);
        run_stream(139, 140, 3);
        chk("t3_relocked", 32'(a_locked), 1);
        run_stream(140, 400, 3);
        chk("t3_err_count", 32'(a_err), 8);
        chk("t3_B_err_count", 32'(b_err), 8);

        // Seven flips per window over four windows stays locked
        start_test();
        run_stream(0, 32 + 1024 + 20, 4);
        chk("t4_err_count", 32'(a_err), 28);
        chk("t4_drops", 32'(a_drops), 0);
        chk("t4_B_saturated", 32'(b_err), 15);

        // All-zero input never locks
        start_test();
        for (int i = 0; i < 40; i++) apply(1, 0, 0, 0);
        chk("t5_locked", 32'(a_locked), 0);
        chk("t5_err_count", 32'(a_err), 0);

        // Inverted stream after lock: saturation, then clear beats a same-cycle error
        start_test();
        run_stream(0, 32, 1);
        for (int i = 0; i < 20; i++) begin
            gen_next(g);
            apply(1, ~g, 0, 0);
        end
        chk("t6_B_saturated", 32'(b_err), 15);
        chk("t6_A_err_count", 32'(a_err), 8);
        chk("t6_A_unlocked", 32'(a_locked), 0);
        gen_next(g);
        apply(1, ~g, 1, 0);
        chk("t6_B_cleared", 32'(b_err), 0);
        chk("t6_B_pulse_kept", 32'(b_pulse), 1);
        chk("t6_B_locked", 32'(b_locked), 1);
        chk("t6_A_cleared", 32'(a_err), 0);

        // Gapped valid with a mid-stream reset at bit 60
        start_test();
        cnt = 0;
        while (cnt < 60) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_next(g); apply(1, g, 0, 0); cnt++;
            end else begin
                apply(0, 1'($urandom_range(0, 1)), 0, 0);
            end
        end
        gen_next(g);
        apply(1, g, 1, 1);
        chk("t7_rst_locked", 32'(a_locked), 0);
        chk("t7_rst_err", 32'(a_err), 0);
        chk("t7_rst_pulse", 32'(a_pulse), 0);
        cnt = 0;
        while (cnt < 300) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_next(g); apply(1, g, 0, 0); cnt++;
            end else begin
                apply(0, 1'($urandom_range(0, 1)), 0, 0);
            end
        end
        chk("t7_relocked", 32'(a_locked), 1);
        chk("t7_err_count", 32'(a_err), 0);
        chk("t7_B_err_count", 32'(b_err), 0);

        apply(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
